hazard_flag_gen: RTL

//  Issue-side partner of the hazard-resolver FSM. Tracks a 3-slot pipeline model (ID, EX, MEM) of issued

---
 rtl/hazard_flag_gen_if.sv | 25 ++
 rtl/hazard_flag_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/hazard_flag_gen_if.sv
// Issue bus between the instruction source (master) and hazard_flag_gen (slave).
interface hazard_flag_gen_if #(
  parameter int REG_W = 3
) ();
  logic             in_valid;
  logic             in_ready;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic             in_load;
  logic             in_store;
  logic             in_branch;
  logic             in_pred;
  logic             in_taken;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_load, in_store, in_branch, in_pred, in_taken,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_load, in_store, in_branch, in_pred, in_taken,
    output in_ready
  );
endinterface

// File: rtl/hazard_flag_gen.sv
// Issue-side partner of the hazard resolver: models ID/EX/MEM slots, decodes
// hazard flags from the slot registers, applies freeze/flush and counts
// stall and flush cycles.
module hazard_flag_gen #(
  parameter int REG_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_flag_gen_if.slave iss,
  input  logic             pc_freeze_i,
  input  logic             do_flush_i,
  output logic             haz_data_o,
  output logic             haz_str_o,
  output logic             haz_ctrl_o,
  output logic             haz_branch_o,
  output logic             haz_fwrd_o,
  output logic             haz_crct_o,
  output logic             retire_valid_o,
  output logic [REG_W-1:0] retire_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             ld;
    logic             st;
    logic             br;
    logic             pred;
    logic             tk;
  } id_slot_t;

  // EX no longer needs source indices; MEM only needs validity and rd.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
    logic             st;
    logic             br;
    logic             pred;
    logic             tk;
  } ex_slot_t;

  id_slot_t         id_q, id_d, issued;
  ex_slot_t         ex_q, ex_d, ex_from_id;
  logic             mem_v_q, mem_v_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_ex, m_mem, load_use, ilk, accept;

  assign m_ex  = ex_q.v & id_q.v & (ex_q.rd != '0) &
                 ((id_q.rs1 == ex_q.rd) | (id_q.rs2 == ex_q.rd));
  assign m_mem = mem_v_q & id_q.v & (mem_rd_q != '0) &
                 ((id_q.rs1 == mem_rd_q) | (id_q.rs2 == mem_rd_q));

  assign load_use = m_ex & ex_q.ld;

  assign haz_data_o   = m_ex | m_mem;
  assign haz_fwrd_o   = haz_data_o & ~load_use;
  assign haz_str_o    = id_q.v & ex_q.v & (id_q.ld | id_q.st) & (ex_q.ld | ex_q.st);
  assign haz_ctrl_o   = (id_q.v & id_q.br) | (ex_q.v & ex_q.br);
  assign haz_branch_o = ex_q.v & ex_q.br;
  assign haz_crct_o   = haz_branch_o & (ex_q.pred == ex_q.tk);

  assign retire_valid_o = mem_v_q;
  assign retire_rd_o    = mem_v_q ? mem_rd_q : '0;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

  // A stalled load-use or memory-port conflict holds ID for one cycle.
  assign ilk = load_use | haz_str_o;

  assign iss.in_ready = rst_n & ~pc_freeze_i & ~do_flush_i & ~ilk;
  assign accept       = iss.in_valid & iss.in_ready;

  assign issued = '{v: 1'b1, rd: iss.in_rd, rs1: iss.in_rs1, rs2: iss.in_rs2,
                    ld: iss.in_load, st: iss.in_store, br: iss.in_branch,
                    pred: iss.in_pred, tk: iss.in_taken};

  assign ex_from_id = '{v: id_q.v, rd: id_q.rd, ld: id_q.ld, st: id_q.st,
                        br: id_q.br, pred: id_q.pred, tk: id_q.tk};

  // Next slot contents: flush beats interlock beats normal advance.
  always_comb begin
    mem_v_d  = ex_q.v;
    mem_rd_d = ex_q.rd;
    ex_d     = ex_from_id;
    id_d     = accept ? issued : '0;
    if (do_flush_i) begin
      id_d = '0;
      ex_d = '0;
    end else if (ilk) begin
      id_d = id_q;
      ex_d = '0;
    end
  end

  // Saturating event counters; they never wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (iss.in_valid & ~iss.in_ready & (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (do_flush_i & (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Slot and counter registers; reset drops in-flight work without a retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q        <= '0;
      ex_q        <= '0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_q        <= id_d;
      ex_q        <= ex_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
